// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each requester owns a one-deep result slot that holds until it is accepted.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  output logic             req0_ready,
  output logic             rsp0_valid,
  output logic [WIDTH-1:0] rsp0_c,
  output logic             rsp0_zero,
  input  logic             rsp0_ready,

  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             req1_ready,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp1_c,
  output logic             rsp1_zero,
  input  logic             rsp1_ready,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero
);

  logic             req_valid [2];
  logic [WIDTH-1:0] req_a     [2];
  logic [WIDTH-1:0] req_b     [2];
  logic [OPW-1:0]   req_op    [2];
  logic             rsp_ready [2];

  logic             elig      [2];
  logic             grant     [2];

  logic             rsp_valid_reg [2];
  logic [WIDTH-1:0] rsp_c_reg     [2];
  logic             rsp_zero_reg  [2];

  // 0 favours requester 0, 1 favours requester 1
  logic             prio_reg;

  assign req_valid[0] = req0_valid;
  assign req_a[0]     = req0_a;
  assign req_b[0]     = req0_b;
  assign req_op[0]    = req0_op;
  assign rsp_ready[0] = rsp0_ready;
  assign req_valid[1] = req1_valid;
  assign req_a[1]     = req1_a;
  assign req_b[1]     = req1_b;
  assign req_op[1]    = req1_op;
  assign rsp_ready[1] = rsp1_ready;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      // A full slot frees up this cycle if its owner is taking the result now
      assign elig[gi] = req_valid[gi] & (~rsp_valid_reg[gi] | rsp_ready[gi]) & ~rst;

      always_ff @(posedge clk) begin
        if (rst) begin
          rsp_valid_reg[gi] <= 1'b0;
          rsp_c_reg[gi]     <= '0;
          rsp_zero_reg[gi]  <= 1'b0;
        end else if (grant[gi]) begin
          rsp_valid_reg[gi] <= 1'b1;
          rsp_c_reg[gi]     <= alu_c;
          rsp_zero_reg[gi]  <= alu_zero;
        end else if (rsp_valid_reg[gi] && rsp_ready[gi]) begin
          rsp_valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_comb begin
    grant[0] = elig[0] & (~elig[1] | ~prio_reg);
    grant[1] = elig[1] & (~elig[0] |  prio_reg);
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    if (grant[0]) begin
      alu_a  = req_a[0];
      alu_b  = req_b[0];
      alu_op = req_op[0];
    end else if (grant[1]) begin
      alu_a  = req_a[1];
      alu_b  = req_b[1];
      alu_op = req_op[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      prio_reg <= 1'b0;
    else if (grant[0])
      prio_reg <= 1'b1;
    else if (grant[1])
      prio_reg <= 1'b0;
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rsp0_valid = rsp_valid_reg[0];
  assign rsp0_c     = rsp_c_reg[0];
  assign rsp0_zero  = rsp_zero_reg[0];
  assign rsp1_valid = rsp_valid_reg[1];
  assign rsp1_c     = rsp_c_reg[1];
  assign rsp1_zero  = rsp_zero_reg[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, round-robin reference model,
// and per-requester result scoreboards drained by a separate monitor.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int OPW   = 5;

  localparam logic [4:0] ALUOp_add  = 5'd3;
  localparam logic [4:0] ALUOp_sub  = 5'd4;
  localparam logic [4:0] ALUOp_sll  = 5'd5;
  localparam logic [4:0] ALUOp_srl  = 5'd6;
  localparam logic [4:0] ALUOp_sra  = 5'd7;
  localparam logic [4:0] ALUOp_and  = 5'd8;
  localparam logic [4:0] ALUOp_or   = 5'd9;
  localparam logic [4:0] ALUOp_xor  = 5'd10;
  localparam logic [4:0] ALUOp_slt  = 5'd11;
  localparam logic [4:0] ALUOp_sltu = 5'd12;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [OPW-1:0]   req0_op, req1_op;
  logic             req0_ready, req1_ready;
  logic             rsp0_valid, rsp1_valid;
  logic [WIDTH-1:0] rsp0_c, rsp1_c;
  logic             rsp0_zero, rsp1_zero;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] alu_a, alu_b, alu_c;
  logic [OPW-1:0]   alu_op;
  logic             alu_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_c(rsp0_c),
    .rsp0_zero(rsp0_zero), .rsp0_ready(rsp0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_c(rsp1_c),
    .rsp1_zero(rsp1_zero), .rsp1_ready(rsp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_zero(alu_zero)
  );

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a, b, input logic [OPW-1:0] op);
    case (op)
      ALUOp_add:  return a + b;
      ALUOp_sub:  return a - b;
      ALUOp_sll:  return a << b[4:0];
      ALUOp_srl:  return a >> b[4:0];
      ALUOp_sra:  return $unsigned($signed(a) >>> b[4:0]);
      ALUOp_and:  return a & b;
      ALUOp_or:   return a | b;
      ALUOp_xor:  return a ^ b;
      ALUOp_slt:  return {31'b0, $signed(a) < $signed(b)};
      ALUOp_sltu: return {31'b0, a < b};
      default:    return '0;
    endcase
  endfunction

  // The shared ALU the arbiter fronts
  always_comb begin
    alu_c    = alu_fn(alu_a, alu_b, alu_op);
    alu_zero = (alu_c == '0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: slot contents, who was served last, pending results
  logic [WIDTH-1:0] m_c [2];
  logic             m_z [2];
  logic             m_v [2];
  int               last_served;
  logic [WIDTH:0]   sb_q0 [$];
  logic [WIDTH:0]   sb_q1 [$];

  always @(negedge clk) begin
    logic v [2], rr [2], e [2];
    logic [WIDTH-1:0] a [2], b [2], res;
    logic [OPW-1:0] op [2];
    int g;
    v = '{req0_valid, req1_valid};
    rr = '{rsp0_ready, rsp1_ready};
    a = '{req0_a, req1_a};
    b = '{req0_b, req1_b};
    op = '{req0_op, req1_op};
    if (rst) begin
      chk("ready0_in_reset", req0_ready, 0);
      chk("ready1_in_reset", req1_ready, 0);
      chk("alu_a_in_reset", alu_a, 0);
      chk("alu_b_in_reset", alu_b, 0);
      chk("alu_op_in_reset", alu_op, 0);
      for (int i = 0; i < 2; i++) begin
        m_v[i] = 1'b0;
        m_c[i] = '0;
        m_z[i] = 1'b0;
      end
      last_served = 1;
      sb_q0.delete();
      sb_q1.delete();
    end else begin
      chk("rsp0_valid", rsp0_valid, m_v[0]);
      chk("rsp1_valid", rsp1_valid, m_v[1]);
      chk("rsp0_c_held", rsp0_c, m_c[0]);
      chk("rsp1_c_held", rsp1_c, m_c[1]);
      chk("rsp0_zero_held", rsp0_zero, m_z[0]);
      chk("rsp1_zero_held", rsp1_zero, m_z[1]);
      for (int i = 0; i < 2; i++)
        e[i] = v[i] && (!m_v[i] || rr[i]);
      // Serve the one not served most recently when both want the ALU
      if (e[0] && e[1]) g = 1 - last_served;
      else if (e[0])    g = 0;
      else if (e[1])    g = 1;
      else              g = -1;
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("alu_a", alu_a, (g >= 0) ? a[g] : '0);
      chk("alu_b", alu_b, (g >= 0) ? b[g] : '0);
      chk("alu_op", alu_op, (g >= 0) ? op[g] : '0);
      for (int i = 0; i < 2; i++) begin
        if (g == i) begin
          res = alu_fn(a[i], b[i], op[i]);
          m_v[i] = 1'b1;
          m_c[i] = res;
          m_z[i] = (res == '0);
          if (i == 0) sb_q0.push_back({m_z[i], res});
          else        sb_q1.push_back({m_z[i], res});
        end else if (m_v[i] && rr[i]) begin
          m_v[i] = 1'b0;
        end
      end
      if (g >= 0) last_served = g;
    end
  end

  // Monitor: every accepted result must match the oldest outstanding issue
  always @(negedge clk) begin
    logic [WIDTH:0] ex;
    if (!rst) begin
      if (rsp0_valid && rsp0_ready) begin
        if (sb_q0.size() == 0) chk("rsp0_unexpected", 1, 0);
        else begin
          ex = sb_q0.pop_front();
          chk("rsp0_c", rsp0_c, ex[WIDTH-1:0]);
          chk("rsp0_zero", rsp0_zero, ex[WIDTH]);
          $display("rsp0 c=0x%08h zero=%0b", rsp0_c, rsp0_zero);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (sb_q1.size() == 0) chk("rsp1_unexpected", 1, 0);
        else begin
          ex = sb_q1.pop_front();
          chk("rsp1_c", rsp1_c, ex[WIDTH-1:0]);
          chk("rsp1_zero", rsp1_zero, ex[WIDTH]);
          $display("rsp1 c=0x%08h zero=%0b", rsp1_c, rsp1_zero);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set0(input logic v, input logic [WIDTH-1:0] a, b, input logic [OPW-1:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic set1(input logic v, input logic [WIDTH-1:0] a, b, input logic [OPW-1:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  initial begin
    rst = 1'b1;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    step(2);
    rst = 1'b0;

    // Single request: 5 + 7
    rsp0_ready = 1'b1;
    set0(1, 5, 7, ALUOp_add);
    step();
    set0(0, 0, 0, 0);
    step(3);

    // Contention: both requesters continuously valid
    rsp1_ready = 1'b1;
    set0(1, 9, 9, ALUOp_sub);
    set1(1, 3, 1, ALUOp_sll);
    step(4);
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(2);

    // Backpressure on requester 0 while requester 1 keeps going
    set0(1, 5, 7, ALUOp_add);
    step();
    rsp0_ready = 1'b0;
    set1(1, 32'h11, 32'h22, ALUOp_xor);
    step(6);
    rsp0_ready = 1'b1;
    set0(1, 32'hF0, 32'h0F, ALUOp_or);
    step();
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(2);

    // Refill a full slot in the same cycle it drains
    rsp0_ready = 1'b0;
    set0(1, 5, 7, ALUOp_add);
    step();
    rsp0_ready = 1'b1;
    set0(1, 32'hF0, 32'h0F, ALUOp_or);
    step();
    set0(0, 0, 0, 0);
    step(2);

    // Reset with both slots full and requests pending
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set0(1, 1, 2, ALUOp_add);
    set1(1, 4, 4, ALUOp_sub);
    step(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(3);

    // Idle
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    step(10);
    set0(1, 2, 3, ALUOp_add);
    set1(1, 6, 3, ALUOp_sub);
    step(2);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      set0($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40),
           5'($urandom_range(0, 15)));
      set1($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) ? $urandom : $urandom_range(0, 40),
           5'($urandom_range(0, 15)));
      rsp0_ready = $urandom_range(0, 2) != 0;
      rsp1_ready = $urandom_range(0, 2) != 0;
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    set0(0, 0, 0, 0);
    set1(0, 0, 0, 0);
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
